mc_dec_ctrl: RTL
================

Name: mc_dec_ctrl

Overview:
- Multi-cycle decoder and sequencer for the LA32 subset core. Replaces the purely combinational decoder with an instruction register and a per-instruction state machine.
- Issues instruction-memory and data-memory requests with valid/ready handshakes, and drives registered datapath controls per state.
- Adds an extended ALU and branch set, illegal-instruction detection, a memory timeout, and a retired-instruction counter.

Parameters:
- EXT_ISA, 1: 0 = only add.w, addi.w, lu12i.w, ld.w, st.w and bne are legal; 1 = full set listed under Behaviour.
- MEM_TO, 16: maximum wait cycles on im/dm handshakes before the error state; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- im_req  out  1  instruction fetch request
- im_ready  in  1  fetch data valid; im_rdata is sampled on im_req && im_ready
- im_rdata  in  32  instruction word
- dm_req  out  1  data access request
- dm_we  out  1  1 = store, 0 = load; valid while dm_req is high
- dm_ready  in  1  data access complete
- br_taken  in  1  branch compare result from BR, sampled in EX
- ir  out  32  instruction register
- rf_raddr1, rf_raddr2  out  5 each  register read addresses
- rf_we  out  1  register write enable
- rf_waddr  out  5  write address
- we_sel  out  2  write-data select: 0 = alu, 1 = mem, 2 = pc+4
- alu_op  out  12  one-hot: b0 add, b1 sub, b2 slt, b3 sltu, b4 and, b6 or, b7 xor, others 0
- alu_src1_sel  out  2  0 = zero, 1 = pc, 2 = rj
- alu_src2_sel  out  2  1 = imm, 2 = rk
- br_type  out  9  one-hot: b0 beq, b1 bne, b2 blt, b3 bge, b6 b, b7 bl, b8 jirl
- imm  out  32  decoded immediate
- pc_we  out  1  PC update pulse
- pc_sel  out  1  0 = pc+4, 1 = target
- illegal  out  1  one-cycle pulse on an undecodable instruction
- err  out  1  sticky timeout flag
- instr_cnt  out  CNT_W  retired instructions; wraps at 2^CNT_W

Behaviour:
- Reset:
  - State goes to IF; ir, imm and all other control outputs are 0; err and instr_cnt are 0.
  - im_req is low during the reset cycle and first asserts on the cycle after rst deasserts.
  - A reset mid-instruction aborts the instruction: no rf_we, no pc_we, no count.
- States: IF, ID, EX, MEM, WB, ERR.
- IF: im_req=1 until im_ready. On the handshake, ir <= im_rdata, then go to ID.
- ID: decode ir; the decoded controls are registered and held stable through EX, MEM and WB.
- EX:
  - ALU, lu12i and pcaddu12i go to WB.
  - ld.w and st.w go to MEM.
  - beq, bne, blt, bge: pc_we=1, pc_sel=br_taken, then go to IF.
  - b: pc_we=1, pc_sel=1, then go to IF.
  - bl and jirl: pc_sel=1 latched, then go to WB.
- MEM: dm_req=1 and dm_we=1 for st.w until dm_ready.
  - ld.w: on dm_ready, go to WB.
  - st.w: on dm_ready, pulse pc_we with pc_sel=0 and go to IF.
- WB:
  - rf_we=1 for one cycle; rf_we is forced to 0 when rf_waddr==0.
  - pc_we=1 with pc_sel=0, except bl/jirl, which use the latched pc_sel=1.
  - Then go to IF.
- Minimum latencies with ready returned the same cycle:
  - ALU / lui / pcaddu12i: 4 cycles.
  - ld.w: 5 cycles.
  - st.w: 4 cycles.
  - Conditional branch and b: 3 cycles.
  - bl and jirl: 4 cycles.
- instr_cnt increments on every pc_we pulse that completes an instruction.
- Decode, using LA32 opcodes:
  - 3R: add.w 0x00020, sub.w 0x00022, slt 0x00024, sltu 0x00025, and 0x00029, or 0x0002a, xor 0x0002b. rj -> raddr1, rk -> raddr2, src1=2, src2=2.
  - addi.w: imm = sext(si12), src2=1.
  - lu12i.w: imm = {si20, 12'b0}, src1=0, src2=1.
  - pcaddu12i: same immediate, src1=1.
  - ld.w / st.w: imm = sext(si12), add. st.w puts rd on raddr2.
  - beq, bne, blt, bge, jirl: imm = sext(offs16)<<2. Compare branches read rj and rd.
  - b / bl: imm = sext({instr[9:0], instr[25:10]})<<2. bl writes r1 with we_sel=2.
  - jirl: writes rd with we_sel=2, src1=2.
- Illegal instructions (including any extended opcode when EXT_ISA=0):
  - In ID: illegal=1 for one cycle, pc_we=1, pc_sel=0, go to IF.
  - No rf_we or dm_req is issued, and instr_cnt does not increment.
- Timeout: with MEM_TO>0, if im_req or dm_req has been held MEM_TO cycles without ready, go to ERR.
  - ERR: err=1 and every request and enable is 0, until rst.
  - A ready arriving in exactly cycle MEM_TO is accepted.

Test Plan:
- Reset, then feed add.w r3,r1,r2 (0x00100823) with im_ready=1 → im_req high from the first post-reset cycle; raddr1=1, raddr2=2, alu_op=0x001; rf_we pulses in cycle 4 with waddr=3; pc_we in that same cycle; instr_cnt=1.
- ld.w r4, r5, -4 with dm_ready delayed 3 cycles → imm=0xFFFFFFFC; dm_req held 4 cycles with dm_we=0; we_sel=1; rf_we one cycle after dm_ready.
- bne offs16=-2 with br_taken=1 then 0 → imm=0xFFFFFFF8, br_type=9'h002; pc_we in EX with pc_sel=1, then pc_sel=0; rf_we never asserts.
- bl with offs26=1 → imm=4; WB writes waddr=1, we_sel=2, pc_sel=1. Also addi.w r0, r0, 5 → rf_we stays 0.
- EXT_ISA=0 fed sub.w → illegal pulse, pc_sel=0, instr_cnt unchanged. EXT_ISA=1 fed 0xFFFFFFFF → same response.
- MEM_TO=4 with dm_ready stuck at 0 during st.w → err=1 after 4 cycles, all requests 0; rst then returns to IF with err=0.

Source files
------------

// File: rtl/mc_dec_ctrl.sv
// mc_dec_ctrl: multi-cycle decoder and sequencer for the LA32 subset core.
// Holds the fetched word in an instruction register, decodes it once in ID,
// and keeps the decoded controls registered until the instruction retires.
module mc_dec_ctrl #(
  parameter int EXT_ISA = 1,
  parameter int MEM_TO  = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             im_req,
  input  logic             im_ready,
  input  logic [31:0]      im_rdata,
  output logic             dm_req,
  output logic             dm_we,
  input  logic             dm_ready,
  input  logic             br_taken,
  output logic [31:0]      ir,
  output logic [4:0]       rf_raddr1,
  output logic [4:0]       rf_raddr2,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [1:0]       we_sel,
  output logic [11:0]      alu_op,
  output logic [1:0]       alu_src1_sel,
  output logic [1:0]       alu_src2_sel,
  output logic [8:0]       br_type,
  output logic [31:0]      imm,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             illegal,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;
  localparam logic [2:0] S_ERR = 3'd5;

  // Instruction class, selects the path through EX/MEM/WB.
  localparam logic [2:0] K_ALU = 3'd0;
  localparam logic [2:0] K_LD  = 3'd1;
  localparam logic [2:0] K_ST  = 3'd2;
  localparam logic [2:0] K_BR  = 3'd3;
  localparam logic [2:0] K_B   = 3'd4;
  localparam logic [2:0] K_LNK = 3'd5;

  localparam bit EXT = (EXT_ISA != 0);
  localparam int TW  = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TO - 1);

  typedef struct packed {
    logic [31:0] imm;
    logic [11:0] alu_op;
    logic [1:0]  src1;
    logic [1:0]  src2;
    logic [8:0]  br_type;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [1:0]  we_sel;
    logic [2:0]  kind;
  } ctl_t;

  logic [2:0]       state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  ctl_t             ctl_q, ctl_d, dec;
  logic             dec_ok;
  logic [11:0]      op3r;
  logic [TW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd, rj, rk;
  logic [31:0]      si12_x, si20_x, offs16_x, offs26_x;

  assign rd       = ir_q[4:0];
  assign rj       = ir_q[9:5];
  assign rk       = ir_q[14:10];
  assign si12_x   = {{20{ir_q[21]}}, ir_q[21:10]};
  assign si20_x   = {ir_q[24:5], 12'b0};
  assign offs16_x = {{14{ir_q[25]}}, ir_q[25:10], 2'b00};
  assign offs26_x = {{4{ir_q[9]}}, ir_q[9:0], ir_q[25:10], 2'b00};

  // Decode the instruction register into a control bundle and a legality flag.
  always_comb begin
    dec    = '0;
    dec_ok = 1'b0;
    op3r   = 12'h000;
    case (ir_q[31:15])
      17'h00020: op3r = 12'h001;
      17'h00022: op3r = 12'h002;
      17'h00024: op3r = 12'h004;
      17'h00025: op3r = 12'h008;
      17'h00029: op3r = 12'h010;
      17'h0002a: op3r = 12'h040;
      17'h0002b: op3r = 12'h080;
      default:   op3r = 12'h000;
    endcase
    if (op3r != 12'h000 && (EXT || op3r == 12'h001)) begin
      dec_ok = 1'b1; dec.alu_op = op3r; dec.src1 = 2'd2; dec.src2 = 2'd2;
      dec.ra1 = rj; dec.ra2 = rk; dec.wa = rd; dec.kind = K_ALU;
    end else if (ir_q[31:22] == 10'h00A) begin
      dec_ok = 1'b1; dec.alu_op = 12'h001; dec.src1 = 2'd2; dec.src2 = 2'd1;
      dec.ra1 = rj; dec.wa = rd; dec.imm = si12_x; dec.kind = K_ALU;
    end else if (ir_q[31:25] == 7'h0A) begin
      dec_ok = 1'b1; dec.alu_op = 12'h001; dec.src1 = 2'd0; dec.src2 = 2'd1;
      dec.wa = rd; dec.imm = si20_x; dec.kind = K_ALU;
    end else if (EXT && ir_q[31:25] == 7'h0E) begin
      dec_ok = 1'b1; dec.alu_op = 12'h001; dec.src1 = 2'd1; dec.src2 = 2'd1;
      dec.wa = rd; dec.imm = si20_x; dec.kind = K_ALU;
    end else if (ir_q[31:22] == 10'h0A2) begin
      dec_ok = 1'b1; dec.alu_op = 12'h001; dec.src1 = 2'd2; dec.src2 = 2'd1;
      dec.ra1 = rj; dec.wa = rd; dec.imm = si12_x; dec.we_sel = 2'd1; dec.kind = K_LD;
    end else if (ir_q[31:22] == 10'h0A6) begin
      dec_ok = 1'b1; dec.alu_op = 12'h001; dec.src1 = 2'd2; dec.src2 = 2'd1;
      dec.ra1 = rj; dec.ra2 = rd; dec.imm = si12_x; dec.kind = K_ST;
    end else begin
      case (ir_q[31:26])
        6'h13: if (EXT) begin
          dec_ok = 1'b1; dec.br_type = 9'h100; dec.alu_op = 12'h001;
          dec.src1 = 2'd2; dec.src2 = 2'd1; dec.ra1 = rj; dec.wa = rd;
          dec.imm = offs16_x; dec.we_sel = 2'd2; dec.kind = K_LNK;
        end
        6'h14: if (EXT) begin
          dec_ok = 1'b1; dec.br_type = 9'h040; dec.imm = offs26_x; dec.kind = K_B;
        end
        6'h15: if (EXT) begin
          dec_ok = 1'b1; dec.br_type = 9'h080; dec.imm = offs26_x;
          dec.wa = 5'd1; dec.we_sel = 2'd2; dec.kind = K_LNK;
        end
        6'h16, 6'h17, 6'h18, 6'h19: if (EXT || ir_q[31:26] == 6'h17) begin
          dec_ok = 1'b1; dec.br_type = 9'h001 << (ir_q[31:26] - 6'h16);
          dec.ra1 = rj; dec.ra2 = rd; dec.imm = offs16_x; dec.kind = K_BR;
        end
        default: dec_ok = 1'b0;
      endcase
    end
  end

  // Sequencer: next state, handshakes, per-state enables and retire counting.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    ctl_d   = ctl_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    im_req  = 1'b0;
    dm_req  = 1'b0;
    dm_we   = 1'b0;
    rf_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = 1'b0;
    illegal = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_IF: begin
        im_req = 1'b1;
        if (im_ready) begin
          ir_d = im_rdata; wait_d = '0; state_d = S_ID;
        end else if (MEM_TO != 0 && wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_ID: begin
        if (dec_ok) begin
          ctl_d = dec; state_d = S_EX;
        end else begin
          illegal = 1'b1; pc_we = 1'b1; state_d = S_IF;
        end
      end
      S_EX: begin
        case (ctl_q.kind)
          K_LD, K_ST: state_d = S_MEM;
          K_BR:       begin pc_we = 1'b1; pc_sel = br_taken; state_d = S_IF; end
          K_B:        begin pc_we = 1'b1; pc_sel = 1'b1;     state_d = S_IF; end
          K_LNK:      begin pc_sel = 1'b1; state_d = S_WB; end
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dm_req = 1'b1;
        dm_we  = (ctl_q.kind == K_ST);
        if (dm_ready) begin
          wait_d = '0;
          if (ctl_q.kind == K_ST) begin
            pc_we = 1'b1; state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (MEM_TO != 0 && wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        rf_we   = (ctl_q.wa != 5'd0);
        pc_we   = 1'b1;
        pc_sel  = (ctl_q.kind == K_LNK);
        state_d = S_IF;
      end
      S_ERR:   err = 1'b1;
      default: state_d = S_IF;
    endcase
    if (rst) begin
      im_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; rf_we = 1'b0;
      pc_we = 1'b0; pc_sel = 1'b0; illegal = 1'b0; err = 1'b0;
    end
    if (pc_we && !illegal) cnt_d = cnt_q + 1'b1;
  end

  assign ir           = ir_q;
  assign imm          = ctl_q.imm;
  assign alu_op       = ctl_q.alu_op;
  assign alu_src1_sel = ctl_q.src1;
  assign alu_src2_sel = ctl_q.src2;
  assign br_type      = ctl_q.br_type;
  assign rf_raddr1    = ctl_q.ra1;
  assign rf_raddr2    = ctl_q.ra2;
  assign rf_waddr     = ctl_q.wa;
  assign we_sel       = ctl_q.we_sel;
  assign instr_cnt    = cnt_q;

  // State, instruction register, decoded controls, wait timer and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      ir_q    <= '0;
      ctl_q   <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctl_q   <= ctl_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
